// File: rtl/cdb_arbiter_pkg.sv
// Shared definitions for the common data bus: tag type, broadcast packet and
// the reserved "no tag" encoding held by the map table for ready registers.
package cdb_arbiter_pkg;

   localparam int CDB_NUM_FU = 5;
   localparam int CDB_TAG_W  = 3;
   localparam int CDB_DATA_W = 32;

   typedef logic [CDB_TAG_W-1:0] RS_TAG;

   // Tag 0 never names a reservation station; it marks a register as ready.
   localparam RS_TAG ZERO_REG = '0;

   typedef struct packed {
      logic                  valid;
      RS_TAG                 tag;
      logic [CDB_DATA_W-1:0] value;
   } CDB_PACKET;

   function automatic logic tag_is_real(input RS_TAG t);
      return t != ZERO_REG;
   endfunction

endpackage

// File: rtl/cdb_arbiter_picker.sv
// Round-robin find-first: the request vector is duplicated, bits below the
// pointer are masked off, and the first surviving bit wins.
module rr_priority_picker #(
   parameter int NUM_FU = 5,
   parameter int IDX_W  = $clog2(NUM_FU)
) (
   input  logic [NUM_FU-1:0] req_i,
   input  logic [IDX_W-1:0]  ptr_i,
   output logic [NUM_FU-1:0] gnt_o,
   output logic [IDX_W-1:0]  idx_o,
   output logic              any_o
);

   logic [2*NUM_FU-1:0] req2;
   logic [2*NUM_FU-1:0] masked2;

   always_comb begin
      req2    = {req_i, req_i};
      masked2 = '0;
      for (int j = 0; j < 2*NUM_FU; j++) begin
         masked2[j] = req2[j] && (j >= int'(ptr_i));
      end
   end

   always_comb begin
      gnt_o = '0;
      idx_o = '0;
      any_o = 1'b0;
      for (int j = 0; j < 2*NUM_FU; j++) begin
         if (masked2[j] && !any_o) begin
            any_o = 1'b1;
            gnt_o[j % NUM_FU] = 1'b1;
            idx_o = IDX_W'(j % NUM_FU);
         end
      end
   end

endmodule

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: one functional-unit result per cycle is chosen
// round-robin and broadcast from a register one cycle after the handshake.
module cdb_arbiter
   import cdb_arbiter_pkg::*;
#(
   parameter int NUM_FU = CDB_NUM_FU,
   parameter int TAG_W  = CDB_TAG_W,
   parameter int DATA_W = CDB_DATA_W,
   parameter int IDX_W  = $clog2(NUM_FU)
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic [NUM_FU-1:0]        fu_valid,
   input  logic [NUM_FU*TAG_W-1:0]  fu_tag,
   input  logic [NUM_FU*DATA_W-1:0] fu_value,
   output logic [NUM_FU-1:0]        fu_ready,
   input  logic                     squash,
   output logic                     cdb_valid,
   output logic [TAG_W-1:0]         cdb_tag,
   output logic [DATA_W-1:0]        cdb_value,
   output logic [IDX_W-1:0]         grant_idx,
   output logic                     bad_tag_err
);

   logic [IDX_W-1:0]  ptr_q, ptr_d;
   CDB_PACKET         pkt_q, pkt_d;
   logic [IDX_W-1:0]  gidx_q, gidx_d;
   logic              bad_q, bad_d;

   logic [NUM_FU-1:0] req_gated;
   logic [NUM_FU-1:0] gnt;
   logic [IDX_W-1:0]  sel_idx;
   logic              xfer;
   logic [TAG_W-1:0]  sel_tag;
   logic [DATA_W-1:0] sel_value;

   // Squash and an asserted reset both suppress every grant.
   assign req_gated = fu_valid & {NUM_FU{reset && !squash}};

   rr_priority_picker #(
      .NUM_FU (NUM_FU),
      .IDX_W  (IDX_W)
   ) u_picker (
      .req_i (req_gated),
      .ptr_i (ptr_q),
      .gnt_o (gnt),
      .idx_o (sel_idx),
      .any_o (xfer)
   );

   assign fu_ready  = gnt;
   assign sel_tag   = fu_tag[sel_idx*TAG_W +: TAG_W];
   assign sel_value = fu_value[sel_idx*DATA_W +: DATA_W];

   always_comb begin
      ptr_d       = ptr_q;
      pkt_d       = pkt_q;
      pkt_d.valid = 1'b0;
      gidx_d      = gidx_q;
      bad_d       = bad_q;
      if (xfer) begin
         ptr_d = (sel_idx == IDX_W'(NUM_FU-1)) ? '0 : sel_idx + 1'b1;
         // A tag-0 result is consumed but never reaches the bus.
         if (tag_is_real(sel_tag)) begin
            pkt_d.valid = 1'b1;
            pkt_d.tag   = sel_tag;
            pkt_d.value = sel_value;
            gidx_d      = sel_idx;
         end else begin
            bad_d = 1'b1;
         end
      end
      if (squash) begin
         pkt_d.valid = 1'b0;
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         ptr_q  <= '0;
         pkt_q  <= '0;
         gidx_q <= '0;
         bad_q  <= 1'b0;
      end else begin
         ptr_q  <= ptr_d;
         pkt_q  <= pkt_d;
         gidx_q <= gidx_d;
         bad_q  <= bad_d;
      end
   end

   assign cdb_valid   = pkt_q.valid;
   assign cdb_tag     = pkt_q.tag;
   assign cdb_value   = pkt_q.value;
   assign grant_idx   = gidx_q;
   assign bad_tag_err = bad_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter with hand-computed expectations and
// per-cycle structural checks on the grant vector and round-robin pointer.
module tb_cdb_arbiter;

   localparam int N  = 5;
   localparam int TW = 3;
   localparam int DW = 32;

   logic            clock;
   logic            reset;
   logic [N-1:0]    fu_valid;
   logic [N*TW-1:0] fu_tag;
   logic [N*DW-1:0] fu_value;
   logic [N-1:0]    fu_ready;
   logic            squash;
   logic            cdb_valid;
   logic [TW-1:0]   cdb_tag;
   logic [DW-1:0]   cdb_value;
   logic [2:0]      grant_idx;
   logic            bad_tag_err;

   int total  = 0;
   int passes = 0;

   cdb_arbiter dut (
      .clock       (clock),
      .reset       (reset),
      .fu_valid    (fu_valid),
      .fu_tag      (fu_tag),
      .fu_value    (fu_value),
      .fu_ready    (fu_ready),
      .squash      (squash),
      .cdb_valid   (cdb_valid),
      .cdb_tag     (cdb_tag),
      .cdb_value   (cdb_value),
      .grant_idx   (grant_idx),
      .bad_tag_err (bad_tag_err)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) passes++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic set_fu(input int i, input logic v, input logic [TW-1:0] t, input logic [DW-1:0] val);
      fu_valid[i]         = v;
      fu_tag[i*TW +: TW]  = t;
      fu_value[i*DW +: DW] = val;
   endtask

   always @(negedge clock) begin
      if (reset) begin
         chk("ready_onehot0", 64'($onehot0(fu_ready)), 64'd1);
         chk("ready_implies_valid", 64'((fu_ready & ~fu_valid) == '0), 64'd1);
         chk("ptr_range", 64'(dut.ptr_q < 3'(N)), 64'd1);
      end
   end

   initial begin
      reset    = 1'b0;
      squash   = 1'b0;
      fu_valid = '0;
      fu_tag   = '0;
      fu_value = '0;
      set_fu(2, 1'b1, 3'd3, 32'h1234);

      // Reset held for two cycles, including a pending request.
      tick();
      tick();
      chk("rst_ready", 64'(fu_ready), 64'd0);
      chk("rst_cdb_valid", 64'(cdb_valid), 64'd0);
      chk("rst_cdb_tag", 64'(cdb_tag), 64'd0);
      chk("rst_cdb_value", 64'(cdb_value), 64'd0);
      chk("rst_grant_idx", 64'(grant_idx), 64'd0);
      chk("rst_bad_tag", 64'(bad_tag_err), 64'd0);
      set_fu(2, 1'b0, 3'd0, 32'h0);
      reset = 1'b1;
      tick();
      chk("idle_cdb_valid", 64'(cdb_valid), 64'd0);
      chk("idle_ready", 64'(fu_ready), 64'd0);

      // Single requester: back-to-back broadcasts.
      set_fu(2, 1'b1, 3'd3, 32'hDEADBEEF);
      for (int k = 0; k < 3; k++) begin
         #1 chk("single_ready", 64'(fu_ready), 64'b00100);
         tick();
         chk("single_valid", 64'(cdb_valid), 64'd1);
         chk("single_tag", 64'(cdb_tag), 64'd3);
         chk("single_value", 64'(cdb_value), 64'hDEADBEEF);
         chk("single_gidx", 64'(grant_idx), 64'd2);
      end
      set_fu(2, 1'b0, 3'd0, 32'h0);
      tick();
      chk("single_drop_valid", 64'(cdb_valid), 64'd0);
      chk("single_hold_tag", 64'(cdb_tag), 64'd3);
      chk("single_ptr", 64'(dut.ptr_q), 64'd3);

      // Grant FU4 so the pointer wraps to 0.
      set_fu(4, 1'b1, 3'd7, 32'h44);
      #1 chk("wrap0_ready", 64'(fu_ready), 64'b10000);
      tick();
      chk("wrap0_tag", 64'(cdb_tag), 64'd7);
      chk("wrap0_gidx", 64'(grant_idx), 64'd4);
      chk("wrap0_ptr", 64'(dut.ptr_q), 64'd0);
      set_fu(4, 1'b0, 3'd0, 32'h0);

      // Full contention from ptr=0.
      for (int i = 0; i < N; i++) set_fu(i, 1'b1, 3'(i + 1), 32'h100 + 32'(i));
      for (int k = 0; k < 6; k++) begin
         #1 chk("all_ready", 64'(fu_ready), 64'(1) << (k % N));
         tick();
         chk("all_valid", 64'(cdb_valid), 64'd1);
         chk("all_tag", 64'(cdb_tag), 64'((k % N) + 1));
         chk("all_value", 64'(cdb_value), 64'h100 + 64'(k % N));
         chk("all_gidx", 64'(grant_idx), 64'(k % N));
         if (k == 0) chk("all_ptr_first", 64'(dut.ptr_q), 64'd1);
      end
      chk("all_ptr_end", 64'(dut.ptr_q), 64'd1);
      for (int i = 0; i < N; i++) set_fu(i, 1'b0, 3'd0, 32'h0);

      // Move ptr to 4, then FU0 and FU4 compete.
      set_fu(3, 1'b1, 3'd6, 32'h33);
      tick();
      chk("pre_wrap_ptr", 64'(dut.ptr_q), 64'd4);
      set_fu(3, 1'b0, 3'd0, 32'h0);
      set_fu(0, 1'b1, 3'd1, 32'hA0);
      set_fu(4, 1'b1, 3'd5, 32'hA4);
      #1 chk("fair_ready_fu4", 64'(fu_ready), 64'b10000);
      tick();
      chk("fair_gidx_fu4", 64'(grant_idx), 64'd4);
      chk("fair_tag_fu4", 64'(cdb_tag), 64'd5);
      chk("fair_ptr0", 64'(dut.ptr_q), 64'd0);
      set_fu(4, 1'b0, 3'd0, 32'h0);
      #1 chk("fair_ready_fu0", 64'(fu_ready), 64'b00001);
      tick();
      chk("fair_gidx_fu0", 64'(grant_idx), 64'd0);
      chk("fair_value_fu0", 64'(cdb_value), 64'hA0);
      chk("fair_ptr1", 64'(dut.ptr_q), 64'd1);
      set_fu(0, 1'b0, 3'd0, 32'h0);

      // Squash the cycle after a transfer.
      set_fu(1, 1'b1, 3'd2, 32'h22);
      #1 chk("sq_ready_pre", 64'(fu_ready), 64'b00010);
      tick();
      chk("sq_first_valid", 64'(cdb_valid), 64'd1);
      chk("sq_first_tag", 64'(cdb_tag), 64'd2);
      squash = 1'b1;
      #1 chk("sq_ready_blocked", 64'(fu_ready), 64'd0);
      tick();
      chk("sq_cdb_valid", 64'(cdb_valid), 64'd0);
      chk("sq_ptr_hold", 64'(dut.ptr_q), 64'd2);
      squash = 1'b0;
      #1 chk("sq_ready_post", 64'(fu_ready), 64'b00010);
      tick();
      chk("sq_retry_valid", 64'(cdb_valid), 64'd1);
      chk("sq_retry_gidx", 64'(grant_idx), 64'd1);
      set_fu(1, 1'b0, 3'd0, 32'h0);

      // Tag-0 result: consumed, flagged, not broadcast.
      set_fu(3, 1'b1, 3'd0, 32'h33);
      #1 chk("bad_ready", 64'(fu_ready), 64'b01000);
      tick();
      chk("bad_cdb_valid", 64'(cdb_valid), 64'd0);
      chk("bad_flag", 64'(bad_tag_err), 64'd1);
      chk("bad_ptr", 64'(dut.ptr_q), 64'd4);
      set_fu(3, 1'b0, 3'd0, 32'h0);
      tick();
      chk("bad_sticky", 64'(bad_tag_err), 64'd1);

      // Mid-stream reset discards the in-flight broadcast.
      set_fu(0, 1'b1, 3'd5, 32'h55);
      tick();
      chk("mid_valid", 64'(cdb_valid), 64'd1);
      chk("mid_tag", 64'(cdb_tag), 64'd5);
      chk("mid_bad_still", 64'(bad_tag_err), 64'd1);
      reset = 1'b0;
      #1;
      chk("mrst_valid", 64'(cdb_valid), 64'd0);
      chk("mrst_tag", 64'(cdb_tag), 64'd0);
      chk("mrst_value", 64'(cdb_value), 64'd0);
      chk("mrst_gidx", 64'(grant_idx), 64'd0);
      chk("mrst_bad", 64'(bad_tag_err), 64'd0);
      chk("mrst_ptr", 64'(dut.ptr_q), 64'd0);
      chk("mrst_ready", 64'(fu_ready), 64'd0);
      tick();
      set_fu(0, 1'b0, 3'd0, 32'h0);
      reset = 1'b1;
      tick();
      chk("post_rst_valid", 64'(cdb_valid), 64'd0);

      $display("%0d/%0d checks passed", passes, total);
      $finish;
   end

endmodule
